// File: rtl/prog_lut.sv
// prog_lut: run-time programmable 2^SEL_W x DATA_W lookup table with a
// pipelined valid/ready lookup port and a self-timed bulk-clear sequencer.
module prog_lut #(
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PIPE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [SEL_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic              busy,
    input  logic              sel_valid,
    output logic              sel_ready,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    localparam int unsigned DEPTH = 1 << SEL_W;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_en;
    logic                accept;
    logic [DATA_W-1:0]   rd_data;
    logic                v1_q;
    logic [DATA_W-1:0]   d1_q;

    // State and clear-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: clear walks every entry once, then returns to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + SEL_W'(1);
                if (cnt_q == SEL_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: busy while clearing; clr beats a same-cycle write.
    always_comb begin
        busy  = 1'b0;
        wr_en = 1'b0;
        case (state_q)
            S_IDLE:  wr_en = we & ~clr;
            S_CLEAR: busy  = 1'b1;
            default: busy  = 1'b0;
        endcase
    end

    assign sel_ready = ~busy;
    assign accept    = sel_valid & ~busy;

    // Write-first bypass so a same-cycle write to the looked-up index is seen.
    assign rd_data = (wr_en && (waddr == sel)) ? wdata : mem_q[sel];

    // Table storage: flops so reset can clear every entry asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    // First lookup stage; data only advances on acceptance so out holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                d1_q <= rd_data;
            end
        end
    end

    if (PIPE == 2) begin : g_pipe2
        logic              v2_q;
        logic [DATA_W-1:0] d2_q;

        // Optional second output register for timing relief.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    d2_q <= d1_q;
                end
            end
        end

        assign out       = d2_q;
        assign out_valid = v2_q;
    end else begin : g_pipe1
        assign out       = d1_q;
        assign out_valid = v1_q;
    end

endmodule

// File: tb/tb_prog_lut.sv
// tb_prog_lut: scoreboard bench for prog_lut across three parameter sets.
module tb_prog_lut;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    // DUT A: SEL_W=2, DATA_W=8, PIPE=1
    logic        rst_a = 1'b1, we_a = 1'b0, clr_a = 1'b0, sv_a = 1'b0;
    logic [1:0]  waddr_a = '0, sel_a = '0;
    logic [7:0]  wdata_a = '0, out_a;
    logic        busy_a, rdy_a, ov_a;
    logic [7:0]  mdl_a [4];

    // DUT B: SEL_W=2, DATA_W=32, PIPE=2
    logic        rst_b = 1'b1, we_b = 1'b0, clr_b = 1'b0, sv_b = 1'b0;
    logic [1:0]  waddr_b = '0, sel_b = '0;
    logic [31:0] wdata_b = '0, out_b;
    logic        busy_b, rdy_b, ov_b;

    // DUT C: SEL_W=3, DATA_W=8, PIPE=1
    logic        rst_c = 1'b1, we_c = 1'b0, clr_c = 1'b0, sv_c = 1'b0;
    logic [2:0]  waddr_c = '0, sel_c = '0;
    logic [7:0]  wdata_c = '0, out_c;
    logic        busy_c, rdy_c, ov_c;
    logic [7:0]  mdl_c [8];

    prog_lut #(.SEL_W(2), .DATA_W(8), .PIPE(1)) u_a (
        .clk(clk), .rst(rst_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .clr(clr_a), .busy(busy_a), .sel_valid(sv_a), .sel_ready(rdy_a),
        .sel(sel_a), .out(out_a), .out_valid(ov_a)
    );

    prog_lut #(.SEL_W(2), .DATA_W(32), .PIPE(2)) u_b (
        .clk(clk), .rst(rst_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .clr(clr_b), .busy(busy_b), .sel_valid(sv_b), .sel_ready(rdy_b),
        .sel(sel_b), .out(out_b), .out_valid(ov_b)
    );

    prog_lut #(.SEL_W(3), .DATA_W(8), .PIPE(1)) u_c (
        .clk(clk), .rst(rst_c), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
        .clr(clr_c), .busy(busy_c), .sel_valid(sv_c), .sel_ready(rdy_c),
        .sel(sel_c), .out(out_c), .out_valid(ov_c)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected results.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: every out_valid must match the head entry on its due cycle.
    always @(negedge clk) begin
        if (!rst_a) begin
            if (ov_a) begin
                if (q_a.size() == 0) check_eq("a_spurious_valid", 64'd1, 64'd0);
                else begin
                    e_a = q_a.pop_front();
                    check_eq("a_data", 64'(out_a), e_a.data);
                    check_eq("a_latency", 64'(cyc), 64'(e_a.due));
                end
            end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
                check_eq("a_missing_valid", 64'd0, 64'd1);
                void'(q_a.pop_front());
            end
        end
        if (!rst_b) begin
            if (ov_b) begin
                if (q_b.size() == 0) check_eq("b_spurious_valid", 64'd1, 64'd0);
                else begin
                    e_b = q_b.pop_front();
                    check_eq("b_data", 64'(out_b), e_b.data);
                    check_eq("b_latency", 64'(cyc), 64'(e_b.due));
                end
            end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
                check_eq("b_missing_valid", 64'd0, 64'd1);
                void'(q_b.pop_front());
            end
        end
        if (!rst_c) begin
            if (ov_c) begin
                if (q_c.size() == 0) check_eq("c_spurious_valid", 64'd1, 64'd0);
                else begin
                    e_c = q_c.pop_front();
                    check_eq("c_data", 64'(out_c), e_c.data);
                    check_eq("c_latency", 64'(cyc), 64'(e_c.due));
                end
            end else if (q_c.size() != 0 && q_c[0].due <= cyc) begin
                check_eq("c_missing_valid", 64'd0, 64'd1);
                void'(q_c.pop_front());
            end
        end
    end

    task automatic wr_a(input logic [1:0] a, input logic [7:0] d);
        we_a = 1'b1; waddr_a = a; wdata_a = d; mdl_a[a] = d;
        step();
        we_a = 1'b0;
    endtask

    task automatic wr_c(input logic [2:0] a, input logic [7:0] d);
        we_c = 1'b1; waddr_c = a; wdata_c = d; mdl_c[a] = d;
        step();
        we_c = 1'b0;
    endtask

    task automatic look_a(input logic [1:0] s);
        exp_t x;
        sv_a = 1'b1; sel_a = s;
        x.data = 64'(mdl_a[s]); x.due = cyc + 1;
        q_a.push_back(x);
    endtask

    task automatic look_c(input logic [2:0] s);
        exp_t x;
        sv_c = 1'b1; sel_c = s;
        x.data = 64'(mdl_c[s]); x.due = cyc + 1;
        q_c.push_back(x);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t x;
        int   nbusy;
        foreach (mdl_a[i]) mdl_a[i] = 8'h00;
        foreach (mdl_c[i]) mdl_c[i] = 8'h00;

        // 1. Reset state is visible before any clock edge.
        #2;
        check_eq("a_rst_out", 64'(out_a), 64'd0);
        check_eq("a_rst_out_valid", 64'(ov_a), 64'd0);
        check_eq("a_rst_busy", 64'(busy_a), 64'd0);
        check_eq("a_rst_sel_ready", 64'(rdy_a), 64'd1);
        @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        look_a(2'd2);
        step();
        sv_a = 1'b0;
        step();

        // 2. Program entries then back-to-back lookups.
        wr_a(2'd0, 8'h11);
        wr_a(2'd1, 8'h22);
        wr_a(2'd2, 8'h33);
        wr_a(2'd3, 8'h44);
        look_a(2'd3); step();
        look_a(2'd0); step();
        look_a(2'd2); step();
        sv_a = 1'b0;
        step();

        // 3. Same-cycle write and lookup of one index returns the new data.
        we_a = 1'b1; waddr_a = 2'd1; wdata_a = 8'hA5;
        mdl_a[1] = 8'hA5;
        look_a(2'd1);
        step();
        we_a = 1'b0; sv_a = 1'b0;
        step();
        step();
        @(negedge clk);
        check_eq("a_out_hold", 64'(out_a), 64'hA5);
        check_eq("a_out_hold_valid", 64'(ov_a), 64'd0);
        step();

        // 4. Clear beats a same-cycle write; busy for exactly four cycles.
        clr_a = 1'b1; we_a = 1'b1; waddr_a = 2'd0; wdata_a = 8'hFF;
        foreach (mdl_a[i]) mdl_a[i] = 8'h00;
        step();
        clr_a = 1'b0; we_a = 1'b0;
        sv_a = 1'b1; sel_a = 2'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("a_clr_busy", 64'(busy_a), 64'd1);
            check_eq("a_clr_sel_ready", 64'(rdy_a), 64'd0);
        end
        sv_a = 1'b0;
        @(negedge clk);
        check_eq("a_clr_busy_end", 64'(busy_a), 64'd0);
        check_eq("a_clr_ready_end", 64'(rdy_a), 64'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            look_a(2'(i));
            step();
        end
        sv_a = 1'b0;
        step();

        // 5. Two-stage pipeline with wide data.
        we_b = 1'b1; waddr_b = 2'd2; wdata_b = 32'hDEADBEEF;
        step();
        we_b = 1'b0;
        sv_b = 1'b1; sel_b = 2'd2;
        x.data = 64'h0000_0000_DEAD_BEEF; x.due = cyc + 2; q_b.push_back(x);
        step();
        sel_b = 2'd0;
        x.data = 64'd0; x.due = cyc + 2; q_b.push_back(x);
        step();
        sv_b = 1'b0;
        step(); step(); step();

        // 6. Asynchronous reset in the middle of a clear.
        for (int i = 0; i < 8; i++) wr_c(3'(i), 8'((i << 4) | 1));
        look_c(3'd5);
        step();
        sv_c = 1'b0;
        step();
        clr_c = 1'b1;
        step();
        clr_c = 1'b0;
        step();
        step();
        #2;
        check_eq("c_pre_rst_busy", 64'(busy_c), 64'd1);
        rst_c = 1'b1;
        q_c.delete();
        foreach (mdl_c[i]) mdl_c[i] = 8'h00;
        #1;
        check_eq("c_rst_busy", 64'(busy_c), 64'd0);
        check_eq("c_rst_out_valid", 64'(ov_c), 64'd0);
        check_eq("c_rst_out", 64'(out_c), 64'd0);
        check_eq("c_rst_sel_ready", 64'(rdy_c), 64'd1);
        step();
        rst_c = 1'b0;
        step(); step(); step();
        clr_c = 1'b1;
        step();
        clr_c = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_c) nbusy++;
        end
        check_eq("c_clear_len", 64'(nbusy), 64'd8);
        step();
        look_c(3'd3);
        step();
        look_c(3'd7);
        step();
        sv_c = 1'b0;
        step(); step();

        check_eq("a_queue_drain", 64'(q_a.size()), 64'd0);
        check_eq("b_queue_drain", 64'(q_b.size()), 64'd0);
        check_eq("c_queue_drain", 64'(q_c.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
